// File: rtl/alu_cmd_issuer.sv
// Command FIFO front-end for an external combinational ALU: issues one
// buffered command at a time, waits SETTLE edges, and returns the sampled result.
package alu_cmd_issuer_pkg;
    typedef struct packed {
        logic [1:0] code;
        logic [3:0] a;
        logic [3:0] b;
    } alu_cmd_t;
endpackage

module alu_cmd_issuer
    import alu_cmd_issuer_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned SETTLE = 1,
    parameter int unsigned CW     = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_code,
    input  logic [3:0]    cmd_a,
    input  logic [3:0]    cmd_b,
    output logic [1:0]    alu_code,
    output logic [3:0]    alu_a,
    output logic [3:0]    alu_b,
    input  logic [4:0]    alu_c,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [4:0]    rsp_data,
    output logic [1:0]    rsp_code,
    output logic          busy,
    output logic [CW-1:0] cnt
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;

    state_t        state, state_d;
    logic [SW-1:0] scnt, scnt_d;
    logic [PW-1:0] wr_ptr, rd_ptr;
    alu_cmd_t      mem [DEPTH];
    logic          push, pop, sample, drop;

    // Ready comes from the registered count only, so a full FIFO never accepts
    // even when the head is popped in the same cycle.
    assign cmd_ready = rst_n & (cnt < CW'(DEPTH));
    assign push      = cmd_valid & cmd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            scnt  <= '0;
        end else begin
            state <= state_d;
            scnt  <= scnt_d;
        end
    end

    always_comb begin
        state_d = state;
        scnt_d  = scnt;
        pop     = 1'b0;
        sample  = 1'b0;
        drop    = 1'b0;
        case (state)
            IDLE: begin
                if (cnt != '0) begin
                    pop     = 1'b1;
                    scnt_d  = '0;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                scnt_d = scnt + SW'(1);
                if (scnt == SW'(SETTLE - 1)) begin
                    sample  = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (rsp_ready) begin
                    drop    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{code: cmd_code, a: cmd_a, b: cmd_b};
    end

    // Launch registers hold the operands steady until the next pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_code  <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_code  <= '0;
            busy      <= 1'b0;
        end else begin
            if (pop) begin
                alu_code <= mem[rd_ptr].code;
                alu_a    <= mem[rd_ptr].a;
                alu_b    <= mem[rd_ptr].b;
            end
            if (sample) begin
                rsp_data  <= alu_c;
                rsp_code  <= alu_code;
                rsp_valid <= 1'b1;
            end else if (drop) begin
                rsp_valid <= 1'b0;
            end
            busy <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Scoreboard bench for alu_cmd_issuer: directed commands with hand-computed
// results, checked by a monitor on every response handshake.
module tb_alu_cmd_issuer;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy;
    logic [1:0] cmd_code, alu_code, rsp_code;
    logic [3:0] cmd_a, cmd_b, alu_a, alu_b;
    logic [4:0] alu_c, rsp_data;
    logic [2:0] cnt;

    logic       cmd_valid3, cmd_ready3, rsp_valid3, rsp_ready3, busy3;
    logic [1:0] cmd_code3, alu_code3, rsp_code3;
    logic [3:0] cmd_a3, cmd_b3, alu_a3, alu_b3;
    logic [4:0] alu_c3, rsp_data3;
    logic [2:0] cnt3;

    int n_checks = 0;
    int n_fail   = 0;
    int n_xfer   = 0;
    int age3     = 100;
    logic busy3_prev = 1'b0;

    logic [6:0] exp_q [$];

    logic [1:0] fc [6] = '{2'd3, 2'd2, 2'd0, 2'd1, 2'd3, 2'd3};
    logic [3:0] fa [6] = '{4'h3, 4'h0, 4'hF, 4'h8, 4'hF, 4'h1};
    logic [3:0] fb [6] = '{4'h4, 4'h1, 4'h6, 4'h1, 4'hF, 4'h1};
    logic [4:0] fe [6] = '{5'h07, 5'h1F, 5'h06, 5'h09, 5'h1E, 5'h02};

    always #5 clk = ~clk;

    function automatic logic [4:0] alu_f(input logic [1:0] c, input logic [3:0] a,
                                         input logic [3:0] b);
        case (c)
            2'b00:   return {1'b0, a & b};
            2'b01:   return {1'b0, a | b};
            2'b10:   return 5'({1'b0, a} - {1'b0, b});
            default: return 5'({1'b0, a} + {1'b0, b});
        endcase
    endfunction

    assign alu_c  = alu_f(alu_code, alu_a, alu_b);
    // Slow ALU: garbage for two cycles after each launch, then the true result.
    assign alu_c3 = (busy3 && age3 < 2) ? 5'h1F : alu_f(alu_code3, alu_a3, alu_b3);

    always @(posedge clk) begin
        #1;
        if (busy3 && !busy3_prev) age3 = 0;
        else if (age3 < 100) age3 = age3 + 1;
        busy3_prev = busy3;
    end

    alu_cmd_issuer #(.DEPTH(4), .SETTLE(1), .CW(3)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_code(cmd_code), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_code(alu_code), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_code(rsp_code),
        .busy(busy), .cnt(cnt)
    );

    alu_cmd_issuer #(.DEPTH(4), .SETTLE(3), .CW(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
        .cmd_code(cmd_code3), .cmd_a(cmd_a3), .cmd_b(cmd_b3),
        .alu_code(alu_code3), .alu_a(alu_a3), .alu_b(alu_b3), .alu_c(alu_c3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_data(rsp_data3), .rsp_code(rsp_code3),
        .busy(busy3), .cnt(cnt3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Response monitor: every handshake pops one expected {code,data}.
    always @(negedge clk) begin : monitor
        logic [6:0] e;
        if (rst_n && rsp_valid && rsp_ready) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rsp_unexpected: got code %0h data %0h, required no response",
                         rsp_code, rsp_data);
            end else begin
                e = exp_q.pop_front();
                check("sb_rsp_code", 32'(rsp_code), 32'(e[6:5]));
                check("sb_rsp_data", 32'(rsp_data), 32'(e[4:0]));
            end
        end
    end

    // Offer one command for one edge; caller is just after a rising edge.
    task automatic offer(input logic [1:0] c, input logic [3:0] a, input logic [3:0] b,
                         input logic [4:0] e, output bit acc);
        cmd_valid = 1'b1;
        cmd_code  = c;
        cmd_a     = a;
        cmd_b     = b;
        acc       = cmd_ready;
        @(posedge clk);
        if (acc) exp_q.push_back({c, e});
        #1;
    endtask

    task automatic send(input logic [1:0] c, input logic [3:0] a, input logic [3:0] b,
                        input logic [4:0] e);
        bit acc = 1'b0;
        for (int i = 0; i < 100 && !acc; i++) offer(c, a, b, e, acc);
        cmd_valid = 1'b0;
        check("send_accepted", 32'(acc), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 200; i++) begin
            if (!busy && cnt == 3'd0 && !rsp_valid) break;
            @(posedge clk);
            #1;
        end
        check(tag, 32'(busy || cnt != 3'd0 || rsp_valid), 32'd0);
    endtask

    task automatic wait_rsp(input string tag);
        for (int i = 0; i < 50; i++) begin
            if (rsp_valid) break;
            @(posedge clk);
            #1;
        end
        check(tag, 32'(rsp_valid), 32'd1);
    endtask

    // F + 1 with SETTLE=1: launch one edge after accept, result one edge later.
    task automatic run_add();
        bit acc;
        offer(2'b11, 4'hF, 4'h1, 5'h10, acc);
        cmd_valid = 1'b0;
        check("add_accept", 32'(acc), 32'd1);
        check("add_cnt_e0", 32'(cnt), 32'd1);
        check("add_busy_e0", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("add_alu_code", 32'(alu_code), 32'd3);
        check("add_alu_a", 32'(alu_a), 32'hF);
        check("add_alu_b", 32'(alu_b), 32'h1);
        check("add_busy_e1", 32'(busy), 32'd1);
        check("add_rsp_valid_e1", 32'(rsp_valid), 32'd0);
        check("add_cnt_e1", 32'(cnt), 32'd0);
        @(posedge clk); #1;
        check("add_rsp_valid_e2", 32'(rsp_valid), 32'd1);
        check("add_rsp_data", 32'(rsp_data), 32'h10);
        check("add_rsp_code", 32'(rsp_code), 32'd3);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("add_rsp_valid_done", 32'(rsp_valid), 32'd0);
        check("add_busy_done", 32'(busy), 32'd0);
    endtask

    task automatic run3(input logic [1:0] c, input logic [3:0] a, input logic [3:0] b,
                        input logic [4:0] e);
        check("s3_cmd_ready", 32'(cmd_ready3), 32'd1);
        cmd_valid3 = 1'b1;
        cmd_code3  = c;
        cmd_a3     = a;
        cmd_b3     = b;
        @(posedge clk); #1;
        cmd_valid3 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            check("s3_rsp_valid_early", 32'(rsp_valid3), 32'd0);
        end
        @(posedge clk); #1;
        check("s3_rsp_valid", 32'(rsp_valid3), 32'd1);
        check("s3_rsp_data", 32'(rsp_data3), 32'(e));
        check("s3_rsp_code", 32'(rsp_code3), 32'(c));
    endtask

    initial begin : stim
        bit acc;
        int x0;
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_code = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
        cmd_valid3 = 1'b0; cmd_code3 = '0; cmd_a3 = '0; cmd_b3 = '0; rsp_ready3 = 1'b1;

        @(posedge clk); #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cnt", 32'(cnt), 32'd0);
        check("rst_alu", 32'({alu_code, alu_a, alu_b}), 32'd0);
        check("rst_rsp", 32'({rsp_code, rsp_data}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("rst_release_cmd_ready", 32'(cmd_ready), 32'd1);

        run_add();

        rsp_ready = 1'b1;
        send(2'b10, 4'h2, 4'h5, 5'h1D);
        send(2'b00, 4'hC, 4'hA, 5'h08);
        send(2'b01, 4'hC, 4'hA, 5'h0E);
        wait_idle("directed_idle");
        rsp_ready = 1'b0;

        // Backpressure: one in flight, four buffered, sixth refused.
        for (int i = 0; i < 6; i++) begin
            offer(fc[i], fa[i], fb[i], fe[i], acc);
            check("fill_accept", 32'(acc), 32'(i < 5));
        end
        cmd_valid = 1'b0;
        check("fill_cnt", 32'(cnt), 32'd4);
        check("fill_cmd_ready", 32'(cmd_ready), 32'd0);
        check("fill_head_hold", 32'({rsp_valid, rsp_data}), 32'({1'b1, 5'h07}));
        x0 = n_xfer;
        rsp_ready = 1'b1;
        wait_idle("fill_drain_idle");
        rsp_ready = 1'b0;
        check("fill_xfers", 32'(n_xfer - x0), 32'd5);
        check("fill_sb_empty", 32'(exp_q.size()), 32'd0);

        // Hold stability with a command waiting behind it.
        send(2'b10, 4'h2, 4'h5, 5'h1D);
        wait_rsp("hold_rsp");
        send(2'b00, 4'hC, 4'hA, 5'h08);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_rsp", 32'({rsp_code, rsp_data}), 32'({2'b10, 5'h1D}));
            check("hold_alu", 32'({alu_code, alu_a, alu_b}), 32'({2'b10, 4'h2, 4'h5}));
            check("hold_cnt", 32'(cnt), 32'd1);
        end
        x0 = n_xfer;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("pulse_one_xfer", 32'(n_xfer - x0), 32'd1);
        check("pulse_valid_low", 32'(rsp_valid), 32'd0);
        wait_rsp("hold_next_rsp");
        check("hold_next_data", 32'({rsp_code, rsp_data}), 32'({2'b00, 5'h08}));
        rsp_ready = 1'b1;
        send(2'b01, 4'hC, 4'hA, 5'h0E);
        wait_idle("hold_idle");
        rsp_ready = 1'b0;

        // Reset in DRIVE with three commands still buffered.
        for (int i = 0; i < 5; i++) offer(fc[i], fa[i], fb[i], fe[i], acc);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_busy", 32'(busy), 32'd1);
        check("pre_rst_valid", 32'(rsp_valid), 32'd0);
        check("pre_rst_cnt", 32'(cnt), 32'd3);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("arst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_cnt", 32'(cnt), 32'd0);
        check("arst_rsp", 32'({rsp_valid, rsp_code, rsp_data}), 32'd0);
        check("arst_alu", 32'({alu_code, alu_a, alu_b}), 32'd0);
        x0 = n_xfer;
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("post_rst_no_rsp", 32'(n_xfer - x0), 32'd0);
        check("post_rst_idle", 32'({busy, cnt}), 32'd0);
        run_add();

        run3(2'b11, 4'h7, 4'h9, 5'h10);
        run3(2'b10, 4'h1, 4'h3, 5'h1E);

        check("final_sb_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: got no end of test, required completion before 50000");
        $fatal(1, "watchdog expired");
    end

endmodule
